// File: rtl/pipeline_hazard_ctrl_if.sv
// Signals exchanged between the pipeline datapath and the hazard controller.
// mem_req/mem_ack: MEM holds mem_req high with its inputs frozen until the
// memory raises mem_ack; a cycle with mem_req=1 and mem_ack=0 is a stall.
interface pipeline_hazard_ctrl_if;
  logic [2:0] ifid_rs;
  logic [2:0] ifid_rt;
  logic       ifid_uses_rt;
  logic       idex_mem_read;
  logic [2:0] idex_rt;
  logic       branch_taken;
  logic       mem_req;
  logic       mem_ack;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_write;
  logic       idex_bubble;
  logic       exmem_hold;

  modport master (
    output ifid_rs, ifid_rt, ifid_uses_rt, idex_mem_read, idex_rt,
           branch_taken, mem_req, mem_ack,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_hold
  );

  modport slave (
    input  ifid_rs, ifid_rt, ifid_uses_rt, idex_mem_read, idex_rt,
           branch_taken, mem_req, mem_ack,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_hold
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use stalls, branch flushes,
// data-memory wait states, plus saturating stall/flush statistics counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_hazard_ctrl_if.slave hz,
  input  logic                  clr_counts,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    FLUSH      = 2'b10,
    MEM_WAIT   = 2'b11
  } state_t;

  state_t cur_state, nxt_state;

  logic load_use;
  logic mem_stall;
  logic pc_write_c, ifid_write_c, ifid_flush_c;
  logic idex_write_c, idex_bubble_c, exmem_hold_c;

  // Register 0 is hardwired to zero, so a load into it never creates a hazard.
  assign load_use = hz.idex_mem_read && (hz.idex_rt != 3'd0) &&
                    ((hz.idex_rt == hz.ifid_rs) ||
                     (hz.ifid_uses_rt && (hz.idex_rt == hz.ifid_rt)));
  assign mem_stall = hz.mem_req && !hz.mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= RUN;
    else        cur_state <= nxt_state;
  end

  always_comb begin
    pc_write_c    = 1'b1;
    ifid_write_c  = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_write_c  = 1'b1;
    idex_bubble_c = 1'b0;
    exmem_hold_c  = 1'b0;
    nxt_state     = RUN;
    unique case (cur_state)
      MEM_WAIT: begin
        if (!hz.mem_ack) begin
          pc_write_c   = 1'b0;
          ifid_write_c = 1'b0;
          idex_write_c = 1'b0;
          exmem_hold_c = 1'b1;
          nxt_state    = MEM_WAIT;
        end
      end
      default: begin
        // RUN, LOAD_STALL and FLUSH share the priority chain; the latter two
        // mask the hazards they have already resolved.
        if (mem_stall) begin
          pc_write_c   = 1'b0;
          ifid_write_c = 1'b0;
          idex_write_c = 1'b0;
          exmem_hold_c = 1'b1;
          nxt_state    = MEM_WAIT;
        end else if (hz.branch_taken && (cur_state != FLUSH)) begin
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
          nxt_state     = FLUSH;
        end else if (load_use && (cur_state == RUN)) begin
          pc_write_c    = 1'b0;
          ifid_write_c  = 1'b0;
          idex_bubble_c = 1'b1;
          nxt_state     = LOAD_STALL;
        end
      end
    endcase
  end

  // All enables are forced low while reset is held.
  assign hz.pc_write    = rst_n && pc_write_c;
  assign hz.ifid_write  = rst_n && ifid_write_c;
  assign hz.ifid_flush  = rst_n && ifid_flush_c;
  assign hz.idex_write  = rst_n && idex_write_c;
  assign hz.idex_bubble = rst_n && idex_bubble_c;
  assign hz.exmem_hold  = rst_n && exmem_hold_c;
  assign state          = cur_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (clr_counts) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!pc_write_c && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
      if (ifid_flush_c && (flush_count != {CNT_W{1'b1}}))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios then random traffic,
// checked against a rule-level model; a CNT_W=2 copy exercises saturation.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic clr_counts;
  logic [1:0]  state, state2;
  logic [15:0] stall_count, flush_count;
  logic [1:0]  stall_count2, flush_count2;

  int total = 0;
  int bad   = 0;

  // Output vector order: {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_hold}
  localparam logic [5:0] O_DEF    = 6'b110100;
  localparam logic [5:0] O_HOLD   = 6'b000001;
  localparam logic [5:0] O_FLUSH  = 6'b111110;
  localparam logic [5:0] O_BUBBLE = 6'b000110;

  // Model: what the pipeline is currently doing, as independent flags.
  bit m_wait, m_stalled, m_flushed;
  int m_sc, m_fc, m_sc2, m_fc2;

  pipeline_hazard_ctrl_if hz ();
  pipeline_hazard_ctrl_if hz2 ();

  assign hz2.ifid_rs       = hz.ifid_rs;
  assign hz2.ifid_rt       = hz.ifid_rt;
  assign hz2.ifid_uses_rt  = hz.ifid_uses_rt;
  assign hz2.idex_mem_read = hz.idex_mem_read;
  assign hz2.idex_rt       = hz.idex_rt;
  assign hz2.branch_taken  = hz.branch_taken;
  assign hz2.mem_req       = hz.mem_req;
  assign hz2.mem_ack       = hz.mem_ack;

  pipeline_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .hz(hz), .clr_counts(clr_counts),
    .state(state), .stall_count(stall_count), .flush_count(flush_count)
  );

  pipeline_hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .hz(hz2), .clr_counts(clr_counts),
    .state(state2), .stall_count(stall_count2), .flush_count(flush_count2)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {hz.pc_write, hz.ifid_write, hz.ifid_flush,
            hz.idex_write, hz.idex_bubble, hz.exmem_hold};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    hz.ifid_rs = 3'd0; hz.ifid_rt = 3'd0; hz.ifid_uses_rt = 1'b0;
    hz.idex_mem_read = 1'b0; hz.idex_rt = 3'd0; hz.branch_taken = 1'b0;
    hz.mem_req = 1'b0; hz.mem_ack = 1'b0; clr_counts = 1'b0;
  endtask

  function automatic int sat_inc(input int v, input int max);
    return (v >= max) ? max : v + 1;
  endfunction

  // Called at a negedge with inputs applied; checks outputs, advances one clock.
  task automatic cycle(input string tag);
    logic ms, lu;
    logic [5:0] eo;
    bit nw, ns, nf, clr;
    #1;
    ms = hz.mem_req && !hz.mem_ack;
    lu = hz.idex_mem_read && (hz.idex_rt != 0) &&
         ((hz.idex_rt == hz.ifid_rs) || (hz.ifid_uses_rt && (hz.idex_rt == hz.ifid_rt)));
    eo = O_DEF; nw = 0; ns = 0; nf = 0;
    if (m_wait) begin
      if (!hz.mem_ack) begin eo = O_HOLD; nw = 1; end
    end else if (ms) begin
      eo = O_HOLD; nw = 1;
    end else if (hz.branch_taken && !m_flushed) begin
      eo = O_FLUSH; nf = 1;
    end else if (lu && !m_stalled && !m_flushed) begin
      eo = O_BUBBLE; ns = 1;
    end
    chk({tag, "_ctrl"}, 32'(outs()), 32'(eo));
    chk({tag, "_ctrl2"}, 32'({hz2.pc_write, hz2.ifid_write, hz2.ifid_flush,
                              hz2.idex_write, hz2.idex_bubble, hz2.exmem_hold}), 32'(eo));
    clr = clr_counts;
    @(posedge clk);
    m_wait = nw; m_stalled = ns; m_flushed = nf;
    if (clr) begin
      m_sc = 0; m_fc = 0; m_sc2 = 0; m_fc2 = 0;
    end else begin
      if (!eo[5]) begin m_sc = sat_inc(m_sc, 65535); m_sc2 = sat_inc(m_sc2, 3); end
      if (eo[3])  begin m_fc = sat_inc(m_fc, 65535); m_fc2 = sat_inc(m_fc2, 3); end
    end
    @(negedge clk);
    chk({tag, "_state"}, 32'(state), m_wait ? 32'd3 : m_flushed ? 32'd2 : m_stalled ? 32'd1 : 32'd0);
    chk({tag, "_state2"}, 32'(state2), 32'(state));
    chk({tag, "_stall_cnt"}, 32'(stall_count), 32'(m_sc));
    chk({tag, "_flush_cnt"}, 32'(flush_count), 32'(m_fc));
    chk({tag, "_stall_cnt2"}, 32'(stall_count2), 32'(m_sc2));
    chk({tag, "_flush_cnt2"}, 32'(flush_count2), 32'(m_fc2));
  endtask

  // Called at a negedge: asserts reset for one clock and checks the reset image.
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    m_wait = 0; m_stalled = 0; m_flushed = 0;
    m_sc = 0; m_fc = 0; m_sc2 = 0; m_fc2 = 0;
    #1;
    chk({tag, "_ctrl"}, 32'(outs()), 32'd0);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_counts"}, {stall_count, flush_count}, 32'd0);
    chk({tag, "_counts2"}, 32'({stall_count2, flush_count2}), 32'd0);
    @(negedge clk);
    chk({tag, "_ctrl_hold"}, 32'(outs()), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    set_idle();
    rst_n = 1'b0;
    m_wait = 0; m_stalled = 0; m_flushed = 0;
    m_sc = 0; m_fc = 0; m_sc2 = 0; m_fc2 = 0;
    @(negedge clk);
    pulse_reset("reset");

    // Load into register 0 never stalls.
    hz.idex_mem_read = 1'b1; hz.idex_rt = 3'd0; hz.ifid_rs = 3'd0;
    cycle("r0_load");
    chk("r0_load_abs_state", 32'(state), 32'd0);

    // Load-use on rs: one bubble cycle, then back to RUN.
    hz.idex_rt = 3'd3; hz.ifid_rs = 3'd3;
    cycle("lu");
    chk("lu_abs_state", 32'(state), 32'd1);
    cycle("lu_release");
    chk("lu_abs_state2", 32'(state), 32'd0);
    chk("lu_abs_stall", 32'(stall_count), 32'd1);

    // Clear, then branch coinciding with load-use resolves as branch only.
    set_idle(); clr_counts = 1'b1;
    cycle("clr1");
    clr_counts = 1'b0;
    hz.idex_mem_read = 1'b1; hz.idex_rt = 3'd5; hz.ifid_rt = 3'd5; hz.ifid_uses_rt = 1'b1;
    hz.branch_taken = 1'b1;
    cycle("br_lu");
    chk("br_lu_abs_state", 32'(state), 32'd2);
    chk("br_lu_abs_flush", 32'(flush_count), 32'd1);
    chk("br_lu_abs_stall", 32'(stall_count), 32'd0);

    // Memory wait: 4 unacked cycles then ack.
    set_idle(); clr_counts = 1'b1;
    cycle("clr2");
    clr_counts = 1'b0;
    hz.mem_req = 1'b1;
    for (int i = 0; i < 4; i++) cycle("mem_wait");
    hz.mem_ack = 1'b1;
    cycle("mem_ack");
    chk("mem_abs_stall", 32'(stall_count), 32'd4);
    chk("mem_abs_state", 32'(state), 32'd0);

    // Saturation on the 2-bit copy, then clear racing a stall.
    set_idle(); clr_counts = 1'b1;
    cycle("clr3");
    clr_counts = 1'b0; hz.mem_req = 1'b1;
    for (int i = 0; i < 5; i++) cycle("sat");
    chk("sat_abs_stall2", 32'(stall_count2), 32'd3);
    clr_counts = 1'b1;
    cycle("sat_clr");
    chk("sat_clr_abs", 32'(stall_count2), 32'd0);
    clr_counts = 1'b0; hz.mem_ack = 1'b1;
    cycle("sat_ack");

    // Reset while waiting on memory aborts the wait.
    set_idle(); hz.mem_req = 1'b1;
    cycle("pre_rst");
    cycle("pre_rst2");
    pulse_reset("mid_rst");
    hz.mem_req = 1'b0;
    #1;
    chk("post_rst_pc_write", 32'(hz.pc_write), 32'd1);
    chk("post_rst_state", 32'(state), 32'd0);
    cycle("post_rst");

    // Random traffic with small register numbers to provoke hazards.
    for (int n = 0; n < 1500; n++) begin
      hz.ifid_rs       = 3'($urandom_range(0, 3));
      hz.ifid_rt       = 3'($urandom_range(0, 3));
      hz.ifid_uses_rt  = 1'($urandom_range(0, 1));
      hz.idex_mem_read = 1'($urandom_range(0, 1));
      hz.idex_rt       = 3'($urandom_range(0, 3));
      hz.branch_taken  = ($urandom_range(0, 5) == 0);
      hz.mem_req       = ($urandom_range(0, 3) == 0);
      hz.mem_ack       = 1'($urandom_range(0, 1));
      clr_counts       = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 300) == 0) pulse_reset("rnd_rst");
      else cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
